// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg: opcode and FSM state encodings shared by the serial ALU controller and its bit slice.
package serial_alu_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_AND    = 2'b00,
        OP_OR     = 2'b01,
        OP_ADDSUB = 2'b10,
        OP_SLT    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/serial_alu_ctrl_alu.sv
// serial_alu_ctrl_alu: single-bit ALU slice (AND, OR, add/sub, pass-through of i3).
module serial_alu_ctrl_alu
    import serial_alu_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       add_sub,
    input  logic       cin,
    input  logic [1:0] op,
    input  logic       i3,
    output logic       result,
    output logic       co
);
    logic bx;

    assign bx     = b ^ add_sub;
    assign result = (op == OP_AND) ? (a & b) :
                    (op == OP_OR)  ? (a | b) :
                    (op == OP_ADDSUB) ? (a ^ bx ^ cin) : i3;
    assign co     = (a & bx) | (cin & (a ^ bx));
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial sequencer pushing WIDTH-bit operations through a one-bit ALU slice, LSB first.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    op_t              op_reg;
    logic             sub_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-2:0] sr;
    logic             s_res;
    logic             s_co;
    logic             eff_sub;
    logic             is_arith;
    logic             ovf;
    logic [WIDTH-1:0] fin;

    // SLT is a subtraction in the slice; its result is rebuilt from sign and overflow below
    serial_alu_ctrl_alu u_alu (
        .a       (a_reg[cnt]),
        .b       (b_reg[cnt]),
        .add_sub (sub_reg),
        .cin     (carry),
        .op      ((op_reg == OP_SLT) ? OP_ADDSUB : op_reg),
        .i3      (1'b0),
        .result  (s_res),
        .co      (s_co)
    );

    assign eff_sub  = (op == OP_SLT) | ((op == OP_ADDSUB) & sub);
    assign is_arith = (op_reg == OP_ADDSUB) | (op_reg == OP_SLT);
    assign ovf      = is_arith & (carry ^ s_co);
    assign fin      = (op_reg == OP_SLT) ? WIDTH'(s_res ^ ovf) : {s_res, sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            op_reg    <= OP_AND;
            sub_reg   <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_reg    <= a;
                    b_reg    <= b;
                    op_reg   <= op_t'(op);
                    sub_reg  <= eff_sub;
                    carry    <= eff_sub;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    carry <= s_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= fin;
                        carry_out <= is_arith & s_co;
                        overflow  <= ovf;
                        zero      <= ~|fin;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        sr[cnt] <= s_res;
                    end
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed self-checking bench for the bit-serial ALU controller (WIDTH=8).
module tb_serial_alu_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    // Called #1 after an edge in IDLE; scrambles inputs after acceptance to show they are latched
    task automatic start_op(input logic [1:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                            output int lat);
        in_valid = 1'b1; op = o; sub = s; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; sub = ~s; a = ~x; b = ~y;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, result, carry_out, overflow, zero} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b res=%h c=%b v=%b z=%b expected all 0",
                     out_valid, result, carry_out, overflow, zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        int lat;
        start_op(2'b10, 1'b0, 8'h7F, 8'h01, lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles expected 8", lat);
        end
        n_checks++;
        if ({result, carry_out, overflow, zero} !== {8'h80, 3'b010}) begin
            n_fail++;
            $display("FAIL add_7f_01: got res=%h c=%b v=%b z=%b expected 80 0 1 0", result, carry_out, overflow, zero);
        end
        release_out();
    endtask

    task automatic test_sub();
        int lat;
        start_op(2'b10, 1'b1, 8'h05, 8'h05, lat);
        n_checks++;
        if (lat !== 8 || {result, carry_out, overflow, zero} !== {8'h00, 3'b101}) begin
            n_fail++;
            $display("FAIL sub_05_05: got lat=%0d res=%h c=%b v=%b z=%b expected 8 00 1 0 1",
                     lat, result, carry_out, overflow, zero);
        end
        release_out();
    endtask

    task automatic test_slt();
        logic [W-1:0] va [3] = '{8'hFD, 8'h7F, 8'h40};
        logic [W-1:0] vb [3] = '{8'h02, 8'h80, 8'h40};
        logic [W+2:0] ve [3] = '{{8'h01, 3'b100}, {8'h00, 3'b011}, {8'h00, 3'b101}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(2'b11, 1'b0, va[i], vb[i], lat);
            n_checks++;
            if (lat !== 8 || {result, carry_out, overflow, zero} !== ve[i]) begin
                n_fail++;
                $display("FAIL slt_%0d: got lat=%0d res=%h c=%b v=%b z=%b expected {res,c,v,z}=%h",
                         i, lat, result, carry_out, overflow, zero, ve[i]);
            end
            release_out();
        end
    endtask

    task automatic test_logic();
        logic [1:0]   vo [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic         vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] ve [4] = '{8'h42, 8'h42, 8'hDB, 8'hDB};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(vo[i], vs[i], 8'hC3, 8'h5A, lat);
            n_checks++;
            if (lat !== 8 || {result, carry_out, overflow, zero} !== {ve[i], 3'b000}) begin
                n_fail++;
                $display("FAIL logic_%0d: got lat=%0d res=%h c=%b v=%b z=%b expected %h 0 0 0",
                         i, lat, result, carry_out, overflow, zero, ve[i]);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(2'b10, 1'b0, 8'h11, 8'h22, lat);
        in_valid = 1'b1; op = 2'b10; sub = 1'b0; a = 8'h01; b = 8'h02;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, result, carry_out, overflow, zero} !== {2'b10, 8'h33, 3'b000}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ov=%b ir=%b res=%h c=%b v=%b z=%b expected 1 0 33 0 0 0",
                         i, out_valid, in_ready, result, carry_out, overflow, zero);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: got in_ready=%b expected 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 8 || result !== 8'h03) begin
            n_fail++;
            $display("FAIL bp_next_op: got lat=%0d res=%h expected 8 03", lat, result);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen = 1'b0;
        in_valid = 1'b1; op = 2'b10; sub = 1'b0; a = 8'hFF; b = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, result, carry_out, overflow, zero} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ov=%b res=%h c=%b v=%b z=%b expected all 0",
                     out_valid, result, carry_out, overflow, zero);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        n_checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got spurious_valid=%b in_ready=%b expected 0/1", seen, in_ready);
        end
        start_op(2'b10, 1'b0, 8'h10, 8'h20, lat);
        n_checks++;
        if (lat !== 8 || {result, carry_out, overflow, zero} !== {8'h30, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid_add: got lat=%0d res=%h c=%b v=%b z=%b expected 8 30 0 0 0",
                     lat, result, carry_out, overflow, zero);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer that runs WIDTH-bit operations through the single-bit ALU slice, one bit per clock, LSB first. It latches operands and opcode under a valid/ready handshake and drives the slice's a, b, add_sub, cin and op inputs. It registers the slice's carry between cycles and shifts result bits into an output word. It sits between the instruction/operand front end and the register-file writeback as the team's compact, area-minimal ALU.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request; high only in IDLE.
- op  input  2  00 AND, 01 OR, 10 ADD/SUB, 11 SLT (signed).
- sub  input  1  for op=10: 0 add, 1 subtract; ignored for AND/OR; forced to 1 internally for SLT.
- a, b  input  WIDTH  operands, sampled on acceptance.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  operation result.
- carry_out  output  1  final carry from the MSB; 0 for AND/OR.
- overflow  output  1  signed overflow for ADD/SUB/SLT; 0 for AND/OR.
- zero  output  1  result == 0.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b, op and effective sub. Set carry register = effective sub. Set bit counter = 0. Go to SHIFT.
  - SHIFT: drive the slice with a_reg[cnt], b_reg[cnt] and the carry register as cin. Drive add_sub = effective sub. Drive op = 10 for SLT, otherwise the latched op. Tie i3 = 0.
    - Each edge: the slice result enters result_sr at bit cnt; the carry register takes co; cnt increments.
    - On the edge where cnt = WIDTH-1: capture the carry into the MSB (cin at that bit) and the final co. Compute overflow = cin_msb ^ co. Go to DONE.
  - DONE: out_valid=1; all outputs held stable. On out_ready, go to IDLE.
- SLT: runs a subtraction over all bits. At the final edge, result = {WIDTH-1 zeros, msb_bit ^ overflow}. carry_out and overflow are still reported from the subtraction.
- AND/OR: the slice carry is ignored; carry_out=0, overflow=0.
- zero is computed on the final registered result.
- Operands and op are ignored while not in IDLE; changes mid-operation have no effect.
- Reset (any time, including mid-SHIFT):
  - state=IDLE, cnt=0, carry register=0.
  - result=0, carry_out=0, overflow=0, zero=0, out_valid=0. in_ready is 1 after reset release.
  - An aborted operation produces no out_valid.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Acceptance edge E0: in_valid & in_ready.
- SHIFT occupies edges E1..E_WIDTH. out_valid rises after E_WIDTH, giving latency of WIDTH cycles from acceptance to out_valid.
- Result, flags and out_valid are registered; no combinational path from inputs to outputs.
- Backpressure: out_valid holds indefinitely with stable outputs until out_ready. The DONE→IDLE transition occurs on the edge where out_ready=1.
- The next acceptance is possible one cycle after that edge. Minimum initiation interval is WIDTH+2 cycles.
- in_ready=0 throughout SHIFT and DONE.

## Structure
- Shared header alu_defs.vh holds:
  - op encodings: OP_AND, OP_OR, OP_ADDSUB, OP_SLT;
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE.
- One sub-module: instantiate the existing single-bit slice alu as the datapath.
- The controller contains only the FSM, operand registers, carry flop, counter and result shift register.

## Test plan
- ADD, WIDTH=8, a=0x7F, b=0x01 → out_valid exactly 8 cycles after acceptance; result=0x80, carry_out=0, overflow=1, zero=0.
- SUB, a=0x05, b=0x05 → result=0x00, carry_out=1, overflow=0, zero=1.
- SLT:
  - a=0xFD, b=0x02 → result=0x01.
  - a=0x7F, b=0x80 → result=0x00, overflow=1.
  - a=b=0x40 → result=0x00.
- AND/OR, a=0xC3, b=0x5A:
  - AND → 0x42;
  - OR → 0xDB;
  - both with carry_out=0 and overflow=0; sub=1 has no effect on either.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is not accepted. Accept occurs 1 cycle after out_ready pulses.
- Reset asserted during SHIFT (cycle 3) → all outputs 0 immediately (asynchronous). After release: in_ready=1, no spurious out_valid, and the next ADD 0x10+0x20 returns 0x30.
